bash_hash_msg_packer: RTL and testbench



---
 rtl/bash_hash_msg_packer_if.sv | 27 ++
 rtl/bash_hash_msg_packer.sv | 103 ++++++++++
 tb/tb_bash_hash_msg_packer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bash_hash_msg_packer_if.sv
// Stream-in / block-out bundle for the bash message packer.
// The packer takes the slave view; the word source and block consumer take the master view.
interface bash_hash_msg_packer_if #(
  parameter int XLEN  = 32,
  parameter int WORDS = 32
);
  logic [XLEN-1:0]       s_data;
  logic [2:0]            s_nbytes;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  logic [XLEN*WORDS-1:0] block;
  logic                  block_first;
  logic                  block_last;
  logic                  block_valid;
  logic                  block_ready;

  modport master (
    output s_data, s_nbytes, s_last, s_valid, block_ready,
    input  s_ready, block, block_first, block_last, block_valid
  );

  modport slave (
    input  s_data, s_nbytes, s_last, s_valid, block_ready,
    output s_ready, block, block_first, block_last, block_valid
  );
endinterface

// File: rtl/bash_hash_msg_packer.sv
// Packs a 32-bit word stream into 1024-bit bash input blocks and applies the
// 0x40-then-zeros padding, adding a pad-only block when the message fills the last block exactly.
module bash_hash_msg_packer #(
  parameter int XLEN  = 32,
  parameter int WORDS = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  bash_hash_msg_packer_if.slave bus
);
  localparam int              PW       = $clog2(WORDS);
  localparam logic [PW-1:0]   PTR_MAX  = PW'(WORDS - 1);
  localparam logic [XLEN-1:0] PAD_WORD = XLEN'(32'h40);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q;
  logic [XLEN-1:0]       mem_q [WORDS];
  logic [PW-1:0]         ptr_q;
  logic                  first_q;
  logic                  last_q;
  logic                  pend_pad;
  logic [XLEN*WORDS-1:0] block_d;

  // Keep bytes below n, place the 0x40 marker at byte n, clear everything above.
  function automatic logic [XLEN-1:0] pad_tail(input logic [XLEN-1:0] d, input logic [2:0] n);
    logic [XLEN-1:0] w;
    w = '0;
    for (int b = 0; b < XLEN/8; b++) begin
      if (b < int'(n))       w[8*b +: 8] = d[8*b +: 8];
      else if (b == int'(n)) w[8*b +: 8] = 8'h40;
    end
    return w;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FILL;
      ptr_q    <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      pend_pad <= 1'b0;
      for (int k = 0; k < WORDS; k++) mem_q[k] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.s_valid) begin
            if (!bus.s_last) begin
              mem_q[ptr_q] <= bus.s_data;
              if (ptr_q == PTR_MAX) begin
                state_q <= HOLD;
                last_q  <= 1'b0;
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end else if (bus.s_nbytes < 3'd4) begin
              mem_q[ptr_q] <= pad_tail(bus.s_data, bus.s_nbytes);
              state_q      <= HOLD;
              last_q       <= 1'b1;
            end else begin
              // Full final word: the marker goes in the next word, or in a whole extra block.
              mem_q[ptr_q] <= bus.s_data;
              state_q      <= HOLD;
              if (ptr_q != PTR_MAX) begin
                mem_q[ptr_q + 1'b1] <= PAD_WORD;
                last_q              <= 1'b1;
              end else begin
                last_q   <= 1'b0;
                pend_pad <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (bus.block_ready) begin
            for (int k = 0; k < WORDS; k++) mem_q[k] <= '0;
            ptr_q   <= '0;
            first_q <= last_q;
            if (pend_pad) begin
              mem_q[0] <= PAD_WORD;
              last_q   <= 1'b1;
              pend_pad <= 1'b0;
            end else begin
              state_q <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  always_comb begin
    block_d = '0;
    for (int k = 0; k < WORDS; k++) block_d[XLEN*k +: XLEN] = mem_q[k];
  end

  assign bus.s_ready     = (state_q == FILL) && !rst_i;
  assign bus.block_valid = (state_q == HOLD);
  assign bus.block       = block_d;
  assign bus.block_first = first_q;
  assign bus.block_last  = last_q;
endmodule

// File: tb/tb_bash_hash_msg_packer.sv
// Directed bench for bash_hash_msg_packer: a byte-level padding model fills a
// scoreboard of expected blocks that is drained as the packer offers blocks.
module tb_bash_hash_msg_packer;
  localparam int XLEN  = 32;
  localparam int WORDS = 32;
  localparam int BW    = XLEN * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bash_hash_msg_packer_if #(.XLEN(XLEN), .WORDS(WORDS)) bus ();

  bash_hash_msg_packer #(.XLEN(XLEN), .WORDS(WORDS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Padded length is the next multiple of 128 bytes strictly above the message length.
  task automatic model_push();
    int         len;
    int         nblk;
    int         idx;
    logic [7:0] bv;
    exp_t       e;
    len  = msg_q.size();
    nblk = len / 128 + 1;
    for (int i = 0; i < nblk; i++) begin
      e.data = '0;
      for (int j = 0; j < 128; j++) begin
        idx = 128 * i + j;
        if (idx < len)       bv = msg_q[idx];
        else if (idx == len) bv = 8'h40;
        else                 bv = 8'h00;
        e.data[8*j +: 8] = bv;
      end
      e.first = (i == 0);
      e.last  = (i == nblk - 1);
      sb.push_back(e);
    end
  endtask

  // Called and returns at a falling edge; the word is accepted on the rising edge in between.
  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic last);
    int cnt;
    cnt = 0;
    bus.s_data   = d;
    bus.s_nbytes = n;
    bus.s_last   = last;
    bus.s_valid  = 1'b1;
    while (bus.s_ready !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) check("ready_timeout", BW'(bus.s_ready), BW'(1));
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (last) check("latency_valid", BW'(bus.block_valid), BW'(1));
  endtask

  task automatic send_msg(input logic [31:0] junk);
    int          len;
    int          nw;
    int          idx;
    logic [31:0] d;
    logic        last;
    logic [2:0]  n;
    len = msg_q.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = junk;
      for (int b = 0; b < 4; b++) begin
        idx = 4 * w + b;
        if (idx < len) d[8*b +: 8] = msg_q[idx];
      end
      last = (w == nw - 1);
      n    = last ? 3'(len - 4 * w) : 3'd4;
      send_word(d, n, last);
    end
  endtask

  task automatic drain(input int nblk);
    int   cnt;
    exp_t e;
    for (int k = 0; k < nblk; k++) begin
      bus.block_ready = 1'b1;
      cnt = 0;
      while (bus.block_valid !== 1'b1 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 200) begin
        check("block_timeout", BW'(bus.block_valid), BW'(1));
      end else if (sb.size() == 0) begin
        check("unexpected_block", BW'(bus.block_valid), BW'(0));
        @(negedge clk);
      end else begin
        e = sb.pop_front();
        check("block_data", bus.block, e.data);
        check("block_first", BW'(bus.block_first), BW'(e.first));
        check("block_last", BW'(bus.block_last), BW'(e.last));
        @(negedge clk);
      end
    end
    bus.block_ready = 1'b0;
  endtask

  initial begin
    exp_t held;
    bus.s_data      = '0;
    bus.s_nbytes    = '0;
    bus.s_last      = 1'b0;
    bus.s_valid     = 1'b0;
    bus.block_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", BW'(bus.s_ready), BW'(0));
    check("rst_valid", BW'(bus.block_valid), BW'(0));
    check("rst_first", BW'(bus.block_first), BW'(1));
    check("rst_last", BW'(bus.block_last), BW'(0));
    check("rst_block", bus.block, '0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", BW'(bus.s_ready), BW'(1));

    // empty message, junk data must be masked
    msg_q.delete();
    model_push();
    send_msg(32'hFFFF_FFFF);
    drain(1);

    // 3-byte "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    model_push();
    send_msg(32'h0000_0000);
    drain(1);

    // 128 bytes, word k = k: data block then pad-only block with valid held high
    msg_q.delete();
    for (int j = 0; j < 128; j++) msg_q.push_back((j % 4 == 0) ? 8'(j / 4) : 8'h00);
    model_push();
    fork
      send_msg(32'h0000_0000);
      drain(1);
    join
    check("pad_valid_next", BW'(bus.block_valid), BW'(1));
    drain(1);

    // 132-byte message followed at once by a 1-byte message
    fork
      begin
        msg_q.delete();
        for (int j = 0; j < 132; j++) msg_q.push_back(8'(j) ^ 8'h5A);
        model_push();
        send_msg(32'h0000_0000);
        msg_q = '{8'h77};
        model_push();
        send_msg(32'h1234_5600);
      end
      drain(3);
    join

    // backpressure: block held 10 cycles while the next message's word waits
    msg_q = '{8'h11};
    model_push();
    send_msg(32'hABCD_EF00);
    held = sb.pop_front();
    msg_q = '{8'h55};
    model_push();
    bus.s_data   = 32'h9988_7755;
    bus.s_nbytes = 3'd1;
    bus.s_last   = 1'b1;
    bus.s_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp_s_ready", BW'(bus.s_ready), BW'(0));
      check("bp_valid", BW'(bus.block_valid), BW'(1));
      check("bp_block", bus.block, held.data);
      check("bp_first", BW'(bus.block_first), BW'(held.first));
      check("bp_last", BW'(bus.block_last), BW'(held.last));
      @(negedge clk);
    end
    bus.block_ready = 1'b1;
    @(negedge clk);
    bus.block_ready = 1'b0;
    check("bp_xfer_on_ready", BW'(bus.block_valid), BW'(0));
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("bp_word_kept", BW'(bus.block_valid), BW'(1));
    drain(1);

    // random-content messages of assorted lengths with junk in unused bytes
    foreach (msg_q[i]) msg_q[i] = 8'h00;
    for (int t = 0; t < 3; t++) begin
      int len;
      len = (t == 0) ? 5 : (t == 1) ? 127 : 200;
      msg_q.delete();
      for (int j = 0; j < len; j++) msg_q.push_back(8'($urandom_range(0, 255)));
      model_push();
      fork
        send_msg(32'hEEEE_EEEE);
        drain(len / 128 + 1);
      join
    end

    // reset in the middle of a fill discards the partial block
    for (int w = 0; w < 10; w++) send_word($urandom, 3'd4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", BW'(bus.s_ready), BW'(0));
    check("midrst_valid", BW'(bus.block_valid), BW'(0));
    check("midrst_block", bus.block, '0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", BW'(bus.s_ready), BW'(1));
    msg_q = '{8'hAA};
    model_push();
    send_msg(32'h0000_0000);
    drain(1);

    repeat (5) @(negedge clk);
    check("no_extra_block", BW'(bus.block_valid), BW'(0));
    check("sb_left", BW'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
